// File: rtl/abs_diff_eval_pkg.sv
// Shared types, defaults and arithmetic helpers for the approximate abs_diff evaluators.
package abs_diff_eval_pkg;

  localparam int unsigned DEF_OPW  = 2;
  localparam int unsigned DEF_RESW = 3;
  localparam int unsigned DEF_ET   = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } eval_state_e;

  function automatic logic [31:0] abs_sub(input logic [31:0] x, input logic [31:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/abs_diff_eval_ref.sv
// Exact |a-b| reference, zero-extended to the netlist result width.
module abs_diff_ref
  import abs_diff_eval_pkg::*;
#(
  parameter int unsigned OPW  = DEF_OPW,
  parameter int unsigned RESW = DEF_RESW
) (
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  output logic [RESW-1:0] diff
);

  always_comb begin
    diff = RESW'(abs_sub(32'(a), 32'(b)));
  end

endmodule

// File: rtl/abs_diff_apx_evaluator.sv
// Exhaustive sweep driver and error monitor for an approximate abs_diff netlist.
// Optional first-failing-vector capture: define ABS_DIFF_EVAL_FIRST_FAIL_EN.
module abs_diff_apx_evaluator
  import abs_diff_eval_pkg::*;
#(
  parameter int unsigned OPW  = DEF_OPW,
  parameter int unsigned RESW = DEF_RESW,
  parameter int unsigned ET   = DEF_ET,
  parameter int unsigned CNTW = 2*OPW+1,
  parameter int unsigned SUMW = RESW+2*OPW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [OPW-1:0]  stim_a,
  output logic [OPW-1:0]  stim_b,
  input  logic [RESW-1:0] approx_res,
  output logic [RESW-1:0] max_err,
  output logic [SUMW-1:0] err_sum,
  output logic [CNTW-1:0] viol_cnt,
`ifdef ABS_DIFF_EVAL_FIRST_FAIL_EN
  output logic            first_fail_vld,
  output logic [2*OPW-1:0] first_fail_vec,
`endif
  output logic            pass
);

  localparam int unsigned    KW     = 2*OPW;
  localparam logic [KW-1:0]  K_LAST = '1;
  localparam logic [RESW-1:0] ET_R  = RESW'(ET);

  eval_state_e     state;
  logic [KW-1:0]   k;
  logic            cap_vld;
  logic [RESW-1:0] cap_res;
  logic [KW-1:0]   cap_vec;
  logic [RESW-1:0] exact;
  logic [RESW-1:0] err;
  logic [RESW-1:0] max_next;
  logic [SUMW:0]   sum_wide;
  logic [SUMW-1:0] sum_next;
  logic            is_viol;
  logic            accept;

  assign stim_a = k[KW-1:OPW];
  assign stim_b = k[OPW-1:0];

  abs_diff_ref #(
    .OPW  (OPW),
    .RESW (RESW)
  ) u_ref (
    .a    (cap_vec[KW-1:OPW]),
    .b    (cap_vec[OPW-1:0]),
    .diff (exact)
  );

  always_comb begin
    accept   = start && ((state == IDLE) || (state == DONE));
    err      = RESW'(abs_sub(32'(cap_res), 32'(exact)));
    max_next = (err > max_err) ? err : max_err;
    sum_wide = {1'b0, err_sum} + (SUMW+1)'(err);
    sum_next = sum_wide[SUMW] ? '1 : sum_wide[SUMW-1:0];
    is_viol  = (err > ET_R);
  end

  // Result of the vector driven last cycle is captured here and scored one cycle later,
  // so the DRAIN cycle scores the final vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      k       <= '0;
      cap_vld <= 1'b0;
      cap_res <= '0;
      cap_vec <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state   <= RUN;
            k       <= '0;
            cap_vld <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
            pass    <= 1'b0;
          end
        end
        RUN: begin
          cap_vld <= 1'b1;
          cap_res <= approx_res;
          cap_vec <= k;
          if (k == K_LAST) begin
            state <= DRAIN;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          cap_vld <= 1'b0;
          state   <= DONE;
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= (max_next <= ET_R);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_err  <= '0;
      err_sum  <= '0;
      viol_cnt <= '0;
    end else if (accept) begin
      max_err  <= '0;
      err_sum  <= '0;
      viol_cnt <= '0;
    end else if (cap_vld) begin
      max_err  <= max_next;
      err_sum  <= sum_next;
      viol_cnt <= viol_cnt + CNTW'(is_viol);
    end
  end

`ifdef ABS_DIFF_EVAL_FIRST_FAIL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
    end else if (accept) begin
      first_fail_vld <= 1'b0;
      first_fail_vec <= '0;
    end else if (cap_vld && is_viol && !first_fail_vld) begin
      first_fail_vld <= 1'b1;
      first_fail_vec <= cap_vec;
    end
  end
`endif

endmodule

// File: tb/tb_abs_diff_apx_evaluator.sv
// Self-checking bench: sweeps with several approximate-netlist models, scored by a behavioural model.
module tb_abs_diff_apx_evaluator;

  localparam int OPW  = 2;
  localparam int RESW = 3;
  localparam int KW   = 2*OPW;
  localparam int N    = 1 << KW;
  localparam int CNTW = 2*OPW+1;
  localparam int SUMW = RESW+2*OPW;
  localparam int EXP_EDGES = N + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  always #5 clk = ~clk;

  logic            busy3, done3, pass3, busy2, done2, pass2;
  logic [OPW-1:0]  stim_a3, stim_b3, stim_a2, stim_b2;
  logic [RESW-1:0] res3, res2, max3, max2;
  logic [SUMW-1:0] sum3, sum2;
  logic [CNTW-1:0] viol3, viol2;
`ifdef ABS_DIFF_EVAL_FIRST_FAIL_EN
  logic            ffv3, ffv2;
  logic [KW-1:0]   ffvec3, ffvec2;
`endif

  int mode;
  logic [RESW-1:0] lut [N];
  int n_checks = 0;
  int n_errors = 0;

  // Netlist stand-in: 0 exact, 1 tied zero, 2 tied all-ones, 3 random table
  function automatic logic [RESW-1:0] approx_of(input int m, input logic [RESW-1:0] entry,
                                                input int a, input int b);
    case (m)
      0:       return RESW'((a > b) ? a - b : b - a);
      1:       return '0;
      2:       return '1;
      default: return entry;
    endcase
  endfunction

  assign res3 = approx_of(mode, lut[{stim_a3, stim_b3}], int'(stim_a3), int'(stim_b3));
  assign res2 = approx_of(mode, lut[{stim_a2, stim_b2}], int'(stim_a2), int'(stim_b2));

  abs_diff_apx_evaluator #(.OPW(OPW), .RESW(RESW), .ET(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy3), .done(done3),
    .stim_a(stim_a3), .stim_b(stim_b3), .approx_res(res3),
    .max_err(max3), .err_sum(sum3), .viol_cnt(viol3),
`ifdef ABS_DIFF_EVAL_FIRST_FAIL_EN
    .first_fail_vld(ffv3), .first_fail_vec(ffvec3),
`endif
    .pass(pass3)
  );

  abs_diff_apx_evaluator #(.OPW(OPW), .RESW(RESW), .ET(2)) dut_et2 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy2), .done(done2),
    .stim_a(stim_a2), .stim_b(stim_b2), .approx_res(res2),
    .max_err(max2), .err_sum(sum2), .viol_cnt(viol2),
`ifdef ABS_DIFF_EVAL_FIRST_FAIL_EN
    .first_fail_vld(ffv2), .first_fail_vec(ffvec2),
`endif
    .pass(pass2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic model(input int m, input int et, output int mx, output int sm,
                       output int vc, output int ffv, output int ffvec);
    int a, b, ex, ap, e;
    mx = 0; sm = 0; vc = 0; ffv = 0; ffvec = 0;
    for (int i = 0; i < N; i++) begin
      a  = i / (1 << OPW);
      b  = i % (1 << OPW);
      ex = (a > b) ? a - b : b - a;
      ap = int'(approx_of(m, lut[i], a, b));
      e  = (ap > ex) ? ap - ex : ex - ap;
      if (e > mx) mx = e;
      sm = sm + e;
      if (sm > (1 << SUMW) - 1) sm = (1 << SUMW) - 1;
      if (e > et) begin
        vc++;
        if (ffv == 0) begin
          ffv = 1;
          ffvec = i;
        end
      end
    end
  endtask

  task automatic wait_done(output int edges);
    edges = 1;
    while (!done3 && edges < 200) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic check_stats(input int m);
    int mx, sm, vc, fv, fvec, mx2, sm2, vc2, fv2, fvec2;
    model(m, 3, mx, sm, vc, fv, fvec);
    model(m, 2, mx2, sm2, vc2, fv2, fvec2);
    chk("done",      done3, 1);
    chk("busy_idle", busy3, 0);
    chk("max_err",   max3, mx);
    chk("err_sum",   sum3, sm);
    chk("viol_cnt",  viol3, vc);
    chk("pass",      pass3, (mx <= 3) ? 1 : 0);
    chk("stim_a_hold", stim_a3, (1 << OPW) - 1);
    chk("stim_b_hold", stim_b3, (1 << OPW) - 1);
    chk("et2_done",  done2, 1);
    chk("et2_busy",  busy2, 0);
    chk("et2_max",   max2, mx2);
    chk("et2_sum",   sum2, sm2);
    chk("et2_viol",  viol2, vc2);
    chk("et2_pass",  pass2, (mx2 <= 2) ? 1 : 0);
    chk("et2_stim",  {stim_a2, stim_b2}, N - 1);
`ifdef ABS_DIFF_EVAL_FIRST_FAIL_EN
    chk("ff_vld",     ffv3, fv);
    chk("ff_vec",     ffvec3, fvec);
    chk("et2_ff_vld", ffv2, fv2);
    chk("et2_ff_vec", ffvec2, fvec2);
`endif
  endtask

  task automatic sweep(input int m);
    int edges;
    mode = m;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("busy_after_start", busy3, 1);
    chk("done_cleared", done3, 0);
    wait_done(edges);
    chk("done_latency", edges, EXP_EDGES);
    check_stats(m);
  endtask

  task automatic randomize_lut();
    for (int i = 0; i < N; i++) lut[i] = RESW'($urandom_range(0, (1 << RESW) - 1));
  endtask

  initial begin
    int edges, guard;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 0;
    randomize_lut();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy3, 0);
    chk("rst_done", done3, 0);
    chk("rst_pass", pass3, 0);
    chk("rst_stim", {stim_a3, stim_b3}, 0);
    chk("rst_stats", {max3, sum3, viol3}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    sweep(0);
    sweep(1);
    sweep(2);
    sweep(0);
    for (int r = 0; r < 4; r++) begin
      randomize_lut();
      repeat ($urandom_range(0, 4)) @(posedge clk);
      sweep(3);
    end

    // start held across a full sweep: only the first DONE cycle restarts
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    wait_done(edges);
    chk("held_latency", edges, EXP_EDGES);
    chk("held_sum_nonzero", (sum3 != 0) ? 1 : 0, 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_done", done3, 0);
    chk("restart_busy", busy3, 1);
    chk("restart_stats", {max3, sum3, viol3}, 0);
    chk("restart_stim", {stim_a3, stim_b3}, 0);
    wait_done(edges);
    chk("restart_latency", edges, EXP_EDGES);
    check_stats(2);

    // asynchronous reset in the middle of a sweep
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    guard = 0;
    while ({stim_a3, stim_b3} != 7 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("reach_k7", {stim_a3, stim_b3}, 7);
    #2; rst_n = 1'b0; #1;
    chk("arst_busy", busy3, 0);
    chk("arst_done", done3, 0);
    chk("arst_pass", pass3, 0);
    chk("arst_stim", {stim_a3, stim_b3}, 0);
    chk("arst_stats", {max3, sum3, viol3}, 0);
    @(posedge clk); #1;
    chk("arst_held_idle", busy3, 0);
    @(negedge clk); rst_n = 1'b1;
    randomize_lut();
    sweep(3);
    sweep(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
